// File: rtl/au_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   clogb2      : max(ceil(log2(x)), 1), used to size index/counter fields
//   arb_state_e : arbiter control state {IDLE, BUSY}
package au_arb_pkg;

    function automatic int clogb2(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/au_rr_arbiter_encode.sv
// One-hot to binary encoder.
//   oh  [WIDTH-1:0] : one-hot (or all-zero) input vector
//   idx [IW-1:0]    : binary index of the set bit, 0 when oh is all-zero
module AU_encode
    import au_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = clogb2(WIDTH)
) (
    input  logic [WIDTH-1:0] oh,
    output logic [IW-1:0]    idx
);

    // OR of the indices of all set bits; exact for one-hot input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) idx = idx | IW'(i);
        end
    end

endmodule

// File: rtl/au_rr_arbiter.sv
// Round-robin lock arbiter sharing one arithmetic-unit slot among WIDTH
// requesters. The grant stays with its owner while the owner requests and
// rotates to the next requester after ptr on release.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   req     [WIDTH-1:0] : level-sensitive request vector
//   gnt     [WIDTH-1:0] : registered one-hot grant (zero when idle)
//   gnt_idx [IW-1:0]    : binary index of the grant (zero when idle)
//   gnt_vld             : any grant bit set
// Optional: define AU_RR_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD
// consecutive owner cycles when another requester is pending.
module au_rr_arbiter
    import au_arb_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = clogb2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    if (WIDTH < 1 || WIDTH > 64 || MAX_HOLD < 1) begin : g_bad_param
        $error("au_rr_arbiter: illegal WIDTH or MAX_HOLD");
    end

    arb_state_e       state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    nxt_ptr;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] win_rot;
    logic [WIDTH-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             owner_hold;
    logic [WIDTH-1:0] others;
    logic             load;
    logic             drop;

    assign owner_hold = |(req & gnt);
    assign others     = req & ~gnt;

`ifdef AU_RR_ARB_TIMEOUT_EN
    localparam int HW = clogb2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_C = HW'(MAX_HOLD);
    logic [HW-1:0] hold_cnt;
`endif

    // Control: pick the candidate set and decide load / drop / hold.
    always_comb begin
        cand      = '0;
        load      = 1'b0;
        drop      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                cand = req;
                if (|req) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!owner_hold) begin
                    cand = others;
                    if (|others) begin
                        load = 1'b1;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`ifdef AU_RR_ARB_TIMEOUT_EN
                else if (hold_cnt == MAX_C && |others) begin
                    // Preemption picks exactly as a release would.
                    cand = others;
                    load = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rotate so ptr lands at bit 0, find first, rotate the one-hot back.
    // Doubling the vector makes the rotation exact for any WIDTH.
    assign rot    = WIDTH'({cand, cand} >> ptr);
    assign win_oh = WIDTH'(({win_rot, win_rot} << ptr) >> WIDTH);

    always_comb begin
        logic found;
        found   = 1'b0;
        win_rot = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && rot[k]) begin
                win_rot[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    AU_encode #(.WIDTH(WIDTH), .IW(IW)) u_enc (
        .oh  (win_oh),
        .idx (win_idx)
    );

    assign nxt_ptr = (win_idx == IW'(WIDTH - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gnt     <= win_oh;
                gnt_idx <= win_idx;
                gnt_vld <= 1'b1;
                ptr     <= nxt_ptr;
            end else if (drop) begin
                gnt     <= '0;
                gnt_idx <= '0;
                gnt_vld <= 1'b0;
            end
        end
    end

`ifdef AU_RR_ARB_TIMEOUT_EN
    // Owner-cycle counter: 1 on every new grant, saturates at MAX_HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (load) begin
            hold_cnt <= HW'(1);
        end else if (drop) begin
            hold_cnt <= '0;
        end else if (state == BUSY && hold_cnt != MAX_C) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

endmodule
